// File: rtl/iq_frame_pkg.sv
// Shared types and constants for the I/Q frame reader.
// The IQ_FRAME_CHECKSUM_EN macro enables the TRAILER state in the top level.
package iq_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StData,
        StTrailer,
        StFlush
    } state_e;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'hA5C3;
    localparam int unsigned SEQ_W         = 15;
    localparam int unsigned OVF_CNT_W     = 16;

    // Header word layout: {magic[31:16], ovf_flag[15], seq[14:0]}
    localparam int unsigned HDR_MAGIC_LSB = 16;
    localparam int unsigned HDR_OVF_BIT   = 15;
    localparam int unsigned HDR_SEQ_LSB   = 0;

    function automatic logic [31:0] make_header(input logic [15:0]      magic,
                                                input logic             ovf,
                                                input logic [SEQ_W-1:0] seq);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 16]   = magic;
        w[HDR_OVF_BIT]           = ovf;
        w[HDR_SEQ_LSB +: SEQ_W]  = seq;
        return w;
    endfunction

endpackage

// File: rtl/iq_frame_reader_out_buf.sv
// Two-entry output buffer for the frame stream: holds {sof, eof, data} per entry
// and presents the head entry on a valid/ready interface.
module iq_out_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        push_sof_i,
    input  logic        push_eof_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic [1:0]  count_o,
    output logic        pop_o
);

    logic [33:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q][31:0];
    // Markers are qualified so a stale head entry never shows SOF/EOF.
    assign sof_o   = valid_o && mem_q[rd_ptr_q][33];
    assign eof_o   = valid_o && mem_q[rd_ptr_q][32];
    assign count_o = count_q;
    assign pop_o   = valid_o && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_sof_i, push_eof_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_o) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_o);
        end
    end

endmodule

// File: rtl/iq_frame_reader.sv
// Drains the DDC I/Q FIFO into header + FRAME_LEN-word frames, flushing the FIFO on overflow.
// Define IQ_FRAME_CHECKSUM_EN to append a modulo-2^32 checksum trailer word to each frame.
module iq_frame_reader
    import iq_frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 256,
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [31:0]          FIFO_Q,
    input  logic                 FIFO_RDEMPTY,
    input  logic                 FIFO_WRFULL,
    output logic                 FIFO_RDREQ,
    output logic                 FIFO_ACLR_REQ,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_SOF,
    output logic                 OUT_EOF,
    output logic [OVF_CNT_W-1:0] OVERFLOW_CNT,
    output logic                 BUSY
);

    localparam logic [16:0] LenAll    = 17'(FRAME_LEN);
    localparam logic [16:0] LenLast   = 17'(FRAME_LEN - 1);
    localparam logic [15:0] FlushLast = 16'(FLUSH_CYC - 1);
`ifdef IQ_FRAME_CHECKSUM_EN
    localparam bit DataEof = 1'b0;
`else
    localparam bit DataEof = 1'b1;
`endif

    state_e               state_q;
    logic [SEQ_W-1:0]     seq_q;
    logic                 ovf_pend_q;
    logic                 ovf_flag_q;
    logic                 wrfull_q;
    logic                 aclr_q;
    logic                 rd_pend_q;
    logic                 word_sent_q;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;
    logic [16:0]          rd_cnt_q;
    logic [16:0]          cap_cnt_q;
    logic [16:0]          tx_cnt_q;
    logic [15:0]          flush_cnt_q;
`ifdef IQ_FRAME_CHECKSUM_EN
    logic [31:0]          sum_q;
`endif

    logic [1:0]  occ;
    logic        xfer;
    logic        wr_rise;
    logic        ctl_push;
    logic        buf_push;
    logic [31:0] push_data;
    logic        push_sof;
    logic        push_eof;
    logic [2:0]  slots;

    assign wr_rise = FIFO_WRFULL && !wrfull_q;

    // Slots freed by this cycle's pop count as available so reads can stream back to back.
    assign slots      = 3'(occ) + 3'(rd_pend_q) - 3'(xfer);
    assign FIFO_RDREQ = (state_q == StData) && !FIFO_RDEMPTY && (slots < 3'd2) &&
                        (rd_cnt_q < LenAll);

    always_comb begin
        ctl_push  = 1'b0;
        push_data = FIFO_Q;
        push_sof  = 1'b0;
        push_eof  = DataEof && (cap_cnt_q == LenLast);
        if (!rd_pend_q && !word_sent_q && occ == 2'd0) begin
            if (state_q == StHeader) begin
                ctl_push  = 1'b1;
                push_data = make_header(HDR_MAGIC, ovf_flag_q, seq_q);
                push_sof  = 1'b1;
                push_eof  = 1'b0;
            end
`ifdef IQ_FRAME_CHECKSUM_EN
            else if (state_q == StTrailer) begin
                ctl_push  = 1'b1;
                push_data = sum_q;
                push_eof  = 1'b1;
            end
`endif
        end
    end

    assign buf_push = rd_pend_q || ctl_push;

    iq_out_buf u_out_buf (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .push_i      (buf_push),
        .push_data_i (push_data),
        .push_sof_i  (push_sof),
        .push_eof_i  (push_eof),
        .ready_i     (OUT_READY),
        .valid_o     (OUT_VALID),
        .data_o      (OUT_DATA),
        .sof_o       (OUT_SOF),
        .eof_o       (OUT_EOF),
        .count_o     (occ),
        .pop_o       (xfer)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            seq_q       <= '0;
            ovf_pend_q  <= 1'b0;
            ovf_flag_q  <= 1'b0;
            wrfull_q    <= 1'b0;
            aclr_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            word_sent_q <= 1'b0;
            ovf_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            cap_cnt_q   <= '0;
            tx_cnt_q    <= '0;
            flush_cnt_q <= '0;
`ifdef IQ_FRAME_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            wrfull_q  <= FIFO_WRFULL;
            rd_pend_q <= FIFO_RDREQ;
            if (wr_rise && ovf_cnt_q != '1) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
            if (FIFO_RDREQ) begin
                rd_cnt_q <= rd_cnt_q + 17'd1;
            end
            if (rd_pend_q) begin
                cap_cnt_q <= cap_cnt_q + 17'd1;
            end
            if (ctl_push) begin
                word_sent_q <= 1'b1;
            end
`ifdef IQ_FRAME_CHECKSUM_EN
            if (xfer) begin
                sum_q <= sum_q + OUT_DATA;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    word_sent_q <= 1'b0;
                    rd_cnt_q    <= '0;
                    cap_cnt_q   <= '0;
                    tx_cnt_q    <= '0;
`ifdef IQ_FRAME_CHECKSUM_EN
                    sum_q       <= '0;
`endif
                    if (ovf_pend_q) begin
                        state_q     <= StFlush;
                        ovf_pend_q  <= 1'b0;
                        aclr_q      <= 1'b1;
                        flush_cnt_q <= '0;
                    end else if (ENABLE && !FIFO_RDEMPTY) begin
                        state_q <= StHeader;
                    end
                end
                StHeader: begin
                    if (xfer) begin
                        state_q     <= StData;
                        ovf_flag_q  <= 1'b0;
                        word_sent_q <= 1'b0;
                    end
                end
                StData: begin
                    if (xfer) begin
                        tx_cnt_q <= tx_cnt_q + 17'd1;
                        if (tx_cnt_q == LenLast) begin
`ifdef IQ_FRAME_CHECKSUM_EN
                            state_q <= StTrailer;
`else
                            seq_q   <= seq_q + 15'd1;
                            state_q <= StIdle;
`endif
                        end
                    end
                end
`ifdef IQ_FRAME_CHECKSUM_EN
                StTrailer: begin
                    if (xfer) begin
                        seq_q   <= seq_q + 15'd1;
                        state_q <= StIdle;
                    end
                end
`endif
                StFlush: begin
                    if (flush_cnt_q == FlushLast) begin
                        aclr_q     <= 1'b0;
                        ovf_flag_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // A new overflow edge wins over the clear on flush entry.
            if (wr_rise) begin
                ovf_pend_q <= 1'b1;
            end
        end
    end

    assign FIFO_ACLR_REQ = aclr_q;
    assign OVERFLOW_CNT  = ovf_cnt_q;
    assign BUSY          = (state_q != StIdle);

endmodule

// File: tb/tb_iq_frame_reader.sv
// Scoreboard bench for iq_frame_reader with a behavioural FIFO model (FRAME_LEN=4).
// Honours IQ_FRAME_CHECKSUM_EN to expect the checksum trailer.
module tb_iq_frame_reader;

    localparam int unsigned FrameLen = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rdempty;
    logic        wrfull = 1'b0;
    logic        rdreq;
    logic        aclr;
    logic [31:0] fifo_q = 32'd0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sof;
    logic        eof;
    logic [15:0] ovf_cnt;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    iq_frame_reader #(
        .FRAME_LEN (FrameLen),
        .HDR_MAGIC (16'hA5C3),
        .FLUSH_CYC (2)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .ENABLE        (enable),
        .FIFO_Q        (fifo_q),
        .FIFO_RDEMPTY  (rdempty),
        .FIFO_WRFULL   (wrfull),
        .FIFO_RDREQ    (rdreq),
        .FIFO_ACLR_REQ (aclr),
        .OUT_DATA      (out_data),
        .OUT_VALID     (out_valid),
        .OUT_READY     (out_ready),
        .OUT_SOF       (sof),
        .OUT_EOF       (eof),
        .OVERFLOW_CNT  (ovf_cnt),
        .BUSY          (busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Normal-mode FIFO model: data appears one cycle after the read request.
    logic [31:0] fifo_mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign rdempty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst || aclr) begin
            rd_ptr <= wr_ptr;
        end else if (rdreq) begin
            check("fifo_read_nonempty", 64'(rdempty), 64'd0);
            fifo_q <= fifo_mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Scoreboard entries are {sof, eof, data}.
    logic [33:0] sb [$];
    logic [14:0] m_seq  = 15'd0;
    logic        m_flag = 1'b0;

    function automatic logic [33:0] sb_pop();
        if (sb.size() != 0) return sb.pop_front();
        return '1;
    endfunction

    int unsigned n_rdreq = 0;
    int unsigned n_aclr  = 0;
    int unsigned n_xfer  = 0;
    logic        prev_v  = 1'b0;
    logic        prev_r  = 1'b0;
    logic [33:0] prev_w  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_while_stalled", 64'({out_valid, sof, eof, out_data}),
                      64'({1'b1, prev_w}));
            end
            if (rdreq) n_rdreq <= n_rdreq + 1;
            if (aclr) n_aclr <= n_aclr + 1;
            if (out_valid && out_ready) begin
                check("out_word", 64'({sof, eof, out_data}), 64'(sb_pop()));
                n_xfer <= n_xfer + 1;
            end
            prev_v <= out_valid;
            prev_r <= out_ready;
            prev_w <= {sof, eof, out_data};
        end
    end

    // Ready driver: constant high, or the 1-0-0-1 pattern when backpressure is on.
    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;
    int         bp_ph   = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_ph];
            bp_ph     = (bp_ph + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic load_frame(input logic [31:0] d [4]);
        logic [31:0] hdr;
        logic [31:0] sum;
        hdr = {16'hA5C3, m_flag, m_seq};
        sb.push_back({2'b10, hdr});
        sum = hdr;
        for (int i = 0; i < 4; i++) begin
`ifdef IQ_FRAME_CHECKSUM_EN
            sb.push_back({2'b00, d[i]});
`else
            sb.push_back({1'b0, (i == 3), d[i]});
`endif
            sum = sum + d[i];
            fifo_mem[wr_ptr % 256] = d[i];
            wr_ptr = wr_ptr + 1;
        end
`ifdef IQ_FRAME_CHECKSUM_EN
        sb.push_back({2'b01, sum});
`endif
    endtask

    task automatic run_frame(input logic [31:0] d [4], input string tag);
        int unsigned rd0;
        int          t;
        rd0 = n_rdreq;
        load_frame(d);
        t = 0;
        while (t < 300 && !(sb.size() == 0 && !busy)) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_done_idle"}, 64'({sb.size() == 0, busy}), 64'd2);
        check({tag, "_rdreq_count"}, 64'(n_rdreq - rd0), 64'(FrameLen));
        m_seq  = m_seq + 15'd1;
        m_flag = 1'b0;
    endtask

    logic [31:0] d0 [4];
    logic [31:0] d1 [4];
    logic [31:0] d2 [4];

    initial begin
        int unsigned a0;
        int unsigned x0;
        int          t;
        d0 = '{32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
        d1 = '{32'hDEADBEEF, 32'h0000FFFF, 32'h80000001, 32'h12345678};
        d2 = '{32'hFFFFFFFF, 32'h00000000, 32'h7FFF8000, 32'hCAFEF00D};

        #12;
        check("reset_outputs",
              64'({out_valid, sof, eof, out_data, rdreq, aclr, busy, ovf_cnt}), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("idle_when_empty", 64'({busy, rdreq, out_valid}), 64'd0);

        run_frame(d0, "basic");

        bp_mode = 1'b1;
        run_frame(d1, "backpressure");
        bp_mode = 1'b0;

        fork
            run_frame(d2, "ovf_frame");
            begin
                int unsigned w;
                w = 0;
                while (!(out_valid && sof) && w < 100) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                @(posedge clk);
                #1 wrfull = 1'b1;
                repeat (3) @(posedge clk);
                #1 wrfull = 1'b0;
            end
        join
        check("ovf_count", 64'(ovf_cnt), 64'd1);
        a0 = n_aclr;
        repeat (8) @(posedge clk);
        #1;
        check("aclr_cycles", 64'(n_aclr - a0), 64'd2);
        check("flush_back_idle", 64'(busy), 64'd0);
        m_flag = 1'b1;
        run_frame(d0, "post_flush");

        @(posedge clk);
        #1;
        force dut.seq_q = 15'h7FFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        m_seq = 15'h7FFF;
        run_frame(d1, "seq_7fff");
        run_frame(d0, "seq_wrap");

        x0 = n_xfer;
        load_frame(d2);
        t = 0;
        while ((n_xfer - x0) < 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reached_mid_frame", 64'(n_xfer - x0), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({out_valid, sof, eof, out_data, rdreq, aclr, busy, ovf_cnt}), 64'd0);
        sb.delete();
        m_seq  = 15'd0;
        m_flag = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_frame(d1, "after_reset");

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
